// File: rtl/nic_pe_driver.sv
// nic_pe_driver: drains the NIC input buffer and sends num_pkts packets to dst_id.
// Define NIC_DRV_RX_CHECK_EN to flag received packets with a bad source ID or signature.
`timescale 1ns/1ps
module nic_pe_driver #(
    parameter int unsigned PACKET_WIDTH = 64,
    parameter logic [3:0]  SRC_ID       = 4'd0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [15:0]             num_pkts,
    input  logic [3:0]              dst_id,
    output logic [1:0]              addr,
    output logic [PACKET_WIDTH-1:0] d_out,
    input  logic [PACKET_WIDTH-1:0] d_in,
    output logic                    nicEn,
    output logic                    nicEnWR,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             tx_count,
    output logic [15:0]             rx_count,
    output logic                    rx_err
);

    localparam logic [1:0] A_IN_BUF  = 2'b00;
    localparam logic [1:0] A_IN_STS  = 2'b01;
    localparam logic [1:0] A_OUT_BUF = 2'b10;
    localparam logic [1:0] A_OUT_STS = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        RX_POLL,
        RX_CHK,
        RX_READ,
        RX_CAP,
        TX_POLL,
        TX_CHK,
        TX_WRITE,
        DONE
    } state_t;

    state_t      state;
    logic [15:0] n_pkts;
    logic [3:0]  dst;
    logic        unused_din;

    assign unused_din = ^d_in;

    // Outputs are loaded on the edge that enters a state, so the access a
    // state performs is on the bus for exactly the cycle that state is live.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr     <= A_IN_BUF;
            d_out    <= '0;
            nicEn    <= 1'b0;
            nicEnWR  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_count <= 16'd0;
            rx_count <= 16'd0;
            n_pkts   <= 16'd0;
            dst      <= 4'd0;
        end else begin
            addr    <= A_IN_BUF;
            d_out   <= '0;
            nicEn   <= 1'b0;
            nicEnWR <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        n_pkts   <= num_pkts;
                        dst      <= dst_id;
                        tx_count <= 16'd0;
                        rx_count <= 16'd0;
                        busy     <= 1'b1;
                        if (num_pkts == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RX_POLL;
                            nicEn <= 1'b1;
                            addr  <= A_IN_STS;
                        end
                    end
                end
                RX_POLL: state <= RX_CHK;
                RX_CHK: begin
                    nicEn <= 1'b1;
                    if (d_in[0]) begin
                        state <= RX_READ;
                        addr  <= A_IN_BUF;
                    end else begin
                        state <= TX_POLL;
                        addr  <= A_OUT_STS;
                    end
                end
                RX_READ: state <= RX_CAP;
                RX_CAP: begin
                    rx_count <= rx_count + 16'd1;
                    state    <= TX_POLL;
                    nicEn    <= 1'b1;
                    addr     <= A_OUT_STS;
                end
                TX_POLL: state <= TX_CHK;
                TX_CHK: begin
                    nicEn <= 1'b1;
                    if (d_in[0]) begin
                        state <= RX_POLL;
                        addr  <= A_IN_STS;
                    end else begin
                        state   <= TX_WRITE;
                        nicEnWR <= 1'b1;
                        addr    <= A_OUT_BUF;
                        d_out   <= {4'h0, dst, SRC_ID, 4'h0, tx_count,
                                    16'hA5A5, tx_count};
                    end
                end
                TX_WRITE: begin
                    tx_count <= tx_count + 16'd1;
                    if (tx_count + 16'd1 == n_pkts) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= RX_POLL;
                        nicEn <= 1'b1;
                        addr  <= A_IN_STS;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef NIC_DRV_RX_CHECK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_err <= 1'b0;
        end else if (state == IDLE && start) begin
            rx_err <= 1'b0;
        end else if (state == RX_CAP &&
                     (d_in[59:56] != SRC_ID || d_in[31:16] != 16'hA5A5)) begin
            rx_err <= 1'b1;
        end
    end
`else
    assign rx_err = 1'b0;
`endif

endmodule
